// File: rtl/pwm_pkg.sv
// Shared definitions for the half-bridge gate sequencer: state encoding and
// default timing constants.
package pwm_pkg;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_LS_ON = 3'd1,
    ST_DT_HS = 3'd2,
    ST_HS_ON = 3'd3,
    ST_DT_LS = 3'd4
  } pwm_state_e;

  localparam int CNT_W_DEF     = 8;
  localparam int DT_CYCLES_DEF = 4;
  localparam int TOFF_MIN_DEF  = 20;
  localparam int TON_MAX_DEF   = 200;

endpackage

// File: rtl/pwm_gate_ctrl_sync2_edge.sv
// Two-flop synchroniser followed by a registered rising-edge pulse.
// The pulse is high for one cycle, three clocks after the pin rises.
module sync2_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic meta_r;
  logic sync_r;
  logic prev_r;
  logic rise_r;

  // Synchronise the pin and register its rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      prev_r <= 1'b0;
      rise_r <= 1'b0;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      prev_r <= sync_r;
      rise_r <= sync_r & ~prev_r;
    end
  end

  assign rise = rise_r;

endmodule

// File: rtl/pwm_gate_ctrl.sv
// Half-bridge gate sequencer: low-side precharge, dead-time in both
// directions, minimum off-time, high-side watchdog and fault shutdown.
// All outputs are registered and change together with the state.
module pwm_gate_ctrl
  import pwm_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DT_CYCLES = DT_CYCLES_DEF,
  parameter int TOFF_MIN  = TOFF_MIN_DEF,
  parameter int TON_MAX   = TON_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic set_req,
  input  logic reset_pwm,
  input  logic fault,
  output logic pwm_set,
  output logic gate_hs,
  output logic gate_ls,
  output logic fault_flag,
  output logic ton_timeout
);

  localparam logic [CNT_W-1:0] DT_LAST   = CNT_W'(DT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TOFF_LAST = CNT_W'(TOFF_MIN - 1);
  localparam logic [CNT_W-1:0] TON_LAST  = CNT_W'(TON_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  pwm_state_e       state_r;
  pwm_state_e       state_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic             pending_r;
  logic             set_edge_s;
  logic             timeout_s;
  logic             pwm_set_r;
  logic             gate_hs_r;
  logic             gate_ls_r;
  logic             fault_flag_r;
  logic             ton_timeout_r;

  sync2_edge u_set_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (set_req),
    .rise  (set_edge_s)
  );

  // Next-state decision; shutdown overrides every normal transition.
  always_comb begin
    state_nx_s = state_r;
    timeout_s  = 1'b0;
    if (fault || !en) begin
      state_nx_s = ST_OFF;
    end else begin
      case (state_r)
        ST_OFF: begin
          if (!fault_flag_r) state_nx_s = ST_LS_ON;
          else               state_nx_s = ST_OFF;
        end
        ST_LS_ON: begin
          if ((pending_r || set_edge_s) && (cnt_r >= TOFF_LAST)) state_nx_s = ST_DT_HS;
          else                                                   state_nx_s = ST_LS_ON;
        end
        ST_DT_HS: begin
          if (cnt_r == DT_LAST) state_nx_s = ST_HS_ON;
          else                  state_nx_s = ST_DT_HS;
        end
        ST_HS_ON: begin
          if (reset_pwm) begin
            state_nx_s = ST_DT_LS;
          end else if (cnt_r == TON_LAST) begin
            state_nx_s = ST_DT_LS;
            timeout_s  = 1'b1;
          end else begin
            state_nx_s = ST_HS_ON;
          end
        end
        ST_DT_LS: begin
          if (cnt_r == DT_LAST) state_nx_s = ST_LS_ON;
          else                  state_nx_s = ST_DT_LS;
        end
        default: state_nx_s = ST_OFF;
      endcase
    end
  end

  // State, phase counter, held trigger, sticky fault and registered gate drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_OFF;
      cnt_r         <= '0;
      pending_r     <= 1'b0;
      pwm_set_r     <= 1'b0;
      gate_hs_r     <= 1'b0;
      gate_ls_r     <= 1'b0;
      fault_flag_r  <= 1'b0;
      ton_timeout_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;

      if (state_nx_s != state_r)                       cnt_r <= '0;
      else if ((state_r != ST_OFF) && (cnt_r != CNT_MAX)) cnt_r <= cnt_r + 1'b1;
      else                                             cnt_r <= cnt_r;

      // Only a trigger seen while staying in LS_ON is held; leaving clears it.
      if ((state_r == ST_LS_ON) && (state_nx_s == ST_LS_ON)) pending_r <= pending_r | set_edge_s;
      else                                                   pending_r <= 1'b0;

      if (fault)    fault_flag_r <= 1'b1;
      else if (!en) fault_flag_r <= 1'b0;
      else          fault_flag_r <= fault_flag_r;

      pwm_set_r     <= (state_nx_s == ST_HS_ON);
      gate_hs_r     <= (state_nx_s == ST_HS_ON);
      gate_ls_r     <= (state_nx_s == ST_LS_ON);
      ton_timeout_r <= timeout_s;
    end
  end

  assign pwm_set     = pwm_set_r;
  assign gate_hs     = gate_hs_r;
  assign gate_ls     = gate_ls_r;
  assign fault_flag  = fault_flag_r;
  assign ton_timeout = ton_timeout_r;

endmodule

// File: tb/tb_pwm_gate_ctrl.sv
// Directed bench for pwm_gate_ctrl at default parameters (DT=4, TOFF_MIN=20,
// TON_MAX=200). Cycle numbers count rising edges after enable is raised.
module tb_pwm_gate_ctrl;

  logic clk = 1'b0;
  logic rst_n, en, set_req, reset_pwm, fault;
  logic pwm_set, gate_hs, gate_ls, fault_flag, ton_timeout;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int hs_cnt, to_cnt;

  pwm_gate_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .set_req     (set_req),
    .reset_pwm   (reset_pwm),
    .fault       (fault),
    .pwm_set     (pwm_set),
    .gate_hs     (gate_hs),
    .gate_ls     (gate_ls),
    .fault_flag  (fault_flag),
    .ton_timeout (ton_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // Fire one synchronised trigger and wait (bounded) for the high side to turn on.
  task automatic trigger_and_wait_hs();
    int n;
    set_req = 1'b1;
    tick();
    set_req = 1'b0;
    n = 0;
    while (!gate_hs && n < 100) begin
      tick();
      n++;
    end
    chk("wait_hs_on", gate_hs, 1'b1);
  endtask

  // Gates must never overlap while out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      assert ((gate_hs & gate_ls) === 1'b0) else begin
        errors++;
        $error("FAIL gate_overlap at time %0t: observed=1 expected=0", $time);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed=hang expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; set_req = 1'b0; reset_pwm = 1'b0; fault = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gate_hs", gate_hs, 1'b0);
    chk("rst_gate_ls", gate_ls, 1'b0);
    chk("rst_pwm_set", pwm_set, 1'b0);
    chk("rst_fault_flag", fault_flag, 1'b0);
    chk("rst_ton_timeout", ton_timeout, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("off_idle_ls", gate_ls, 1'b0);

    // 1. Startup and first trigger.
    cyc = 0;
    en  = 1'b1;
    tick();
    chk("startup_ls_c1", gate_ls, 1'b1);
    run_to(30);
    set_req = 1'b1;
    tick();
    set_req = 1'b0;
    run_to(33);
    chk("trig_ls_c33", gate_ls, 1'b1);
    tick();
    chk("trig_ls_c34", gate_ls, 1'b0);
    chk("trig_hs_c34", gate_hs, 1'b0);
    run_to(37);
    chk("dt_hs_c37", gate_hs, 1'b0);
    tick();
    chk("hs_on_c38", gate_hs, 1'b1);
    chk("pwm_set_c38", pwm_set, 1'b1);

    // 2. Normal end of on-time.
    run_to(40);
    reset_pwm = 1'b1;
    tick();
    reset_pwm = 1'b0;
    chk("rpwm_hs_c41", gate_hs, 1'b0);
    chk("rpwm_pwmset_c41", pwm_set, 1'b0);
    chk("rpwm_ls_c41", gate_ls, 1'b0);
    run_to(44);
    chk("dt_ls_c44", gate_ls, 1'b0);
    tick();
    chk("ls_on_c45", gate_ls, 1'b1);

    // 3. Early trigger held until minimum off-time; reset_pwm in LS_ON ignored.
    run_to(47);
    set_req = 1'b1;
    tick();
    set_req = 1'b0;
    run_to(55);
    reset_pwm = 1'b1;
    tick();
    reset_pwm = 1'b0;
    chk("ls_ignore_rpwm_ls", gate_ls, 1'b1);
    chk("ls_ignore_rpwm_hs", gate_hs, 1'b0);
    run_to(64);
    chk("toff_ls_c64", gate_ls, 1'b1);
    tick();
    chk("toff_ls_c65", gate_ls, 1'b0);
    run_to(68);
    chk("early_hs_c68", gate_hs, 1'b0);
    tick();
    chk("early_hs_c69", gate_hs, 1'b1);

    // 4. Watchdog: no reset_pwm.
    hs_cnt = 0;
    to_cnt = 0;
    while (gate_hs && hs_cnt < 300) begin
      hs_cnt++;
      if (ton_timeout) to_cnt++;
      tick();
    end
    chk_int("wd_hs_width", hs_cnt, 200);
    chk_int("wd_early_pulse", to_cnt, 0);
    chk_int("wd_cycle", cyc, 269);
    chk("wd_timeout_pulse", ton_timeout, 1'b1);
    chk("wd_ls_dt", gate_ls, 1'b0);
    tick();
    chk("wd_timeout_single", ton_timeout, 1'b0);
    run_to(272);
    chk("wd_dt_ls_c272", gate_ls, 1'b0);
    tick();
    chk("wd_ls_on_c273", gate_ls, 1'b1);

    // 5. Fault during HS_ON, sticky flag, cleared by en=0.
    trigger_and_wait_hs();
    tick();
    fault = 1'b1;
    tick();
    fault = 1'b0;
    chk("fault_hs", gate_hs, 1'b0);
    chk("fault_ls", gate_ls, 1'b0);
    chk("fault_flag_set", fault_flag, 1'b1);
    repeat (6) tick();
    chk("fault_hold_ls", gate_ls, 1'b0);
    chk("fault_hold_flag", fault_flag, 1'b1);
    en = 1'b0;
    tick();
    chk("fault_flag_clear", fault_flag, 1'b0);
    chk("en0_ls", gate_ls, 1'b0);
    en = 1'b1;
    tick();
    chk("resume_ls", gate_ls, 1'b1);

    // 6. reset_pwm and fault together: fault wins, no DT_LS -> LS_ON.
    repeat (20) tick();
    trigger_and_wait_hs();
    reset_pwm = 1'b1;
    fault     = 1'b1;
    tick();
    reset_pwm = 1'b0;
    fault     = 1'b0;
    chk("prio_hs", gate_hs, 1'b0);
    chk("prio_flag", fault_flag, 1'b1);
    repeat (6) tick();
    chk("prio_stays_off", gate_ls, 1'b0);

    // Asynchronous reset mid-operation.
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    chk("pre_rst_ls", gate_ls, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ls", gate_ls, 1'b0);
    chk("async_rst_flag", fault_flag, 1'b0);
    tick();
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_gate_ctrl.md
Name: pwm_gate_ctrl

Overview:
Half-bridge gate sequencer for the constant-on-time buck loop. It takes the comparator trigger `set_req` and the one-cycle end-of-on-time pulse `reset_pwm`, and drives the high-side and low-side gates with dead-time, minimum off-time, a max-on watchdog and fault shutdown. Its `pwm_set` output feeds the on-time stage, which is rising-edge triggered and returns `reset_pwm`.

Parameters:
- CNT_W, 8, width of the shared phase counter.
- DT_CYCLES, 4, dead-time in clk cycles (≥1).
- TOFF_MIN, 20, minimum low-side on-time in cycles (≥1).
- TON_MAX, 200, high-side watchdog limit in cycles (< 2^CNT_W).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  converter enable, synchronous level.
- set_req  in  1  comparator trigger, asynchronous; synchronised internally.
- reset_pwm  in  1  single-cycle end-of-on-time pulse from the on-time stage.
- fault  in  1  synchronous overcurrent/UVLO fault, level.
- pwm_set  out  1  high while in HS_ON; drives the on-time stage's set input.
- gate_hs  out  1  high-side gate, registered.
- gate_ls  out  1  low-side gate, registered.
- fault_flag  out  1  sticky fault indicator.
- ton_timeout  out  1  one-cycle pulse when the watchdog forces turn-off.

Behaviour:
- Reset:
  - State OFF; counter 0; all outputs 0; pending 0; sync flops 0.
- set_req path:
  - 2-FF synchroniser, then rising-edge detect. The edge is valid 3 clk after the pin rises.
- Registered outputs:
  - gate_hs = (state==HS_ON); gate_ls = (state==LS_ON); pwm_set = (state==HS_ON).
  - All three are registered and change in the same cycle as the state.
  - gate_hs and gate_ls are never high together.
- Counter:
  - Cleared on every state change; otherwise increments in DT_HS, DT_LS, LS_ON and HS_ON.
  - Saturates at all-ones.
- State OFF:
  - Both gates low.
  - Moves to LS_ON when en=1, fault=0 and fault_flag=0. This precharges the bootstrap; no dead-time is needed because both gates are already low.
- State LS_ON:
  - A `pending` flag latches any set edge seen in this state.
  - Moves to DT_HS when (pending or set edge this cycle) and counter ≥ TOFF_MIN-1.
  - A set edge before minimum off-time is held, not dropped.
- State DT_HS:
  - Both gates low; moves to HS_ON when counter == DT_CYCLES-1.
  - Dead-time is therefore exactly DT_CYCLES cycles.
- State HS_ON:
  - reset_pwm sampled high → DT_LS next cycle.
  - If counter == TON_MAX-1 with no reset_pwm → DT_LS, and ton_timeout pulses for 1 cycle.
  - reset_pwm and the timeout in the same cycle → DT_LS with no timeout pulse.
- State DT_LS:
  - Both gates low; moves to LS_ON after DT_CYCLES cycles; pending cleared.
- Ignored inputs:
  - reset_pwm outside HS_ON is ignored.
  - Set edges in DT_HS, HS_ON and DT_LS are ignored and not latched.
- Shutdown and fault:
  - From any state, en=0 or fault=1 → OFF next cycle, gates low in that cycle.
  - fault has priority over every other transition.
  - fault=1 sets fault_flag, which holds until en=0 is sampled. OFF is only left when fault_flag=0.
  - Shutdown from HS_ON goes straight to OFF; no dead-time is needed since both gates drop.
- reset_pwm arriving with fault in the same cycle: fault wins.
- Reset asserted mid-operation: all outputs drop asynchronously.

Decomposition:
- Package pwm_pkg holds:
  - State encoding: OFF=0, LS_ON=1, DT_HS=2, HS_ON=3, DT_LS=4, 3-bit.
  - Default parameter constants.
- Sub-module sync2_edge: 2-FF synchroniser plus rising-edge pulse, reusable for other comparator inputs.
- FSM and counter stay in pwm_gate_ctrl.

Test Plan (defaults DT=4, TOFF_MIN=20, TON_MAX=200):
1. Startup: reset, then en=1 → gate_ls=1 at cycle 1. Pulse set_req at cycle 30 → gate_ls falls at cycle 34, gate_hs rises at cycle 38, pwm_set=1 with it.
2. Normal cycle: in HS_ON, drive reset_pwm 1 cycle at cycle N → gate_hs=0 at N+1, gate_ls=1 at N+5. Assert gate_hs&gate_ls never true across the whole run.
3. Early trigger: set edge visible 5 cycles into LS_ON → held; DT_HS entered only after counter reaches 19. LS_ON lasts exactly 20 cycles.
4. Watchdog: no reset_pwm → gate_hs high exactly 200 cycles, ton_timeout single pulse, then DT_LS.
5. Fault: fault=1 during HS_ON → both gates 0 next cycle, fault_flag=1. en stays 1 → remains OFF. en=0 then 1 → flag clears, LS_ON resumes.
6. Priority: reset_pwm and fault in the same cycle → OFF, not DT_LS. A reset_pwm pulse during LS_ON → no state change.
